conv_sequencer: RTL and testbench

CONV_SEQUENCER -- requirements
Module: conv_sequencer

---
 rtl/conv_sequencer_pkg.sv | 25 ++
 rtl/conv_sequencer_addr_gen.sv | 42 ++++
 rtl/conv_sequencer.sv | 150 +++++++++++++++
 tb/tb_conv_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sequencer_pkg.sv
// rtl/conv_sequencer_pkg.sv - shared types and constants for the convolution sequencer
package conv_sequencer_pkg;

    localparam int ACC_W     = 40;
    localparam int X_W       = 16;
    localparam int X_PAD_W   = 16;
    localparam int X_EXT_W   = ACC_W - X_W - X_PAD_W;
    localparam int NUM_U_DEF = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RJ_RD,
        S_COEF_RD,
        S_DATA_RD,
        S_ADD,
        S_SHIFT,
        S_DONE
    } state_t;

    // Sample lands at bits 31:16 of the accumulator, sign-extended above.
    function automatic logic [ACC_W-1:0] x_to_operand(input logic [X_W-1:0] x);
        return {{X_EXT_W{x[X_W-1]}}, x, {X_PAD_W{1'b0}}};
    endfunction

endpackage

// File: rtl/conv_sequencer_addr_gen.sv
// rtl/conv_sequencer_addr_gen.sv - coefficient address counter and wrapped sample address
module conv_addr_gen #(
    parameter int COEF_AW = 9
) (
    input  logic               sClk,
    input  logic               ALUReset_n,
    input  logic               i_load,
    input  logic               i_data_en,
    input  logic               i_coef_inc,
    input  logic [7:0]         i_ptr,
    input  logic [7:0]         i_k,
    output logic [COEF_AW-1:0] o_coef_addr,
    output logic [7:0]         o_data_addr
);

    logic [7:0]         r_ptr;
    logic [COEF_AW-1:0] r_coef_addr;
    logic [7:0]         r_data_addr;

    always_ff @(posedge sClk or negedge ALUReset_n) begin
        if (!ALUReset_n) begin
            r_ptr       <= '0;
            r_coef_addr <= '0;
            r_data_addr <= '0;
        end else begin
            if (i_load) begin
                r_ptr       <= i_ptr;
                r_coef_addr <= '0;
            end else if (i_coef_inc) begin
                r_coef_addr <= r_coef_addr + COEF_AW'(1);
            end
            // 8-bit subtraction gives the circular sample-buffer wrap for free.
            if (i_data_en) begin
                r_data_addr <= r_ptr - i_k;
            end
        end
    end

    assign o_coef_addr = r_coef_addr;
    assign o_data_addr = r_data_addr;

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - FSM and accumulator producing one convolution output per start
// Optional sticky signed-overflow flag when CONV_OVF_DETECT_EN is defined.
module conv_sequencer
    import conv_sequencer_pkg::*;
#(
    parameter int NUM_U   = NUM_U_DEF,
    parameter int COEF_AW = 9
) (
    input  logic               sClk,
    input  logic               ALUReset_n,
    input  logic               start,
    input  logic [7:0]         xnew_ptr,
    output logic [3:0]         rj_addr,
    input  logic [7:0]         rj_data,
    output logic [COEF_AW-1:0] coef_addr,
    input  logic [8:0]         coef_data,
    output logic [7:0]         data_addr,
    input  logic [15:0]        data_data,
    output logic               alu_sign,
    output logic [ACC_W-1:0]   alu_opA,
    output logic [ACC_W-1:0]   alu_opB,
    input  logic [ACC_W-1:0]   alu_result,
    input  logic               alu_ready,
    output logic               busy,
    output logic               done,
`ifdef CONV_OVF_DETECT_EN
    output logic               ovf,
`endif
    output logic [ACC_W-1:0]   y_out
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_rj_ph;
    logic [3:0]         r_u;
    logic [7:0]         r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   r_y_out;
    logic               r_sign;
    logic               w_start_ok;
    logic               w_add_cap;
    logic               w_last_u;
    logic [ACC_W-1:0]   w_acc_shr;

    assign w_start_ok = (r_state == S_IDLE) && start;
    assign w_add_cap  = (r_state == S_ADD) && alu_ready;
    assign w_last_u   = (r_u == 4'(NUM_U - 1));
    assign w_acc_shr  = {r_acc[ACC_W-1], r_acc[ACC_W-1:1]};

    conv_addr_gen #(.COEF_AW(COEF_AW)) u_addr_gen (
        .sClk        (sClk),
        .ALUReset_n  (ALUReset_n),
        .i_load      (w_start_ok),
        .i_data_en   (r_state == S_COEF_RD),
        .i_coef_inc  (w_add_cap),
        .i_ptr       (xnew_ptr),
        .i_k         (coef_data[7:0]),
        .o_coef_addr (coef_addr),
        .o_data_addr (data_addr)
    );

    always_ff @(posedge sClk or negedge ALUReset_n) begin
        if (!ALUReset_n) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (start) w_state_nxt = S_RJ_RD;
            // Second RJ_RD cycle sees the group's count and decides.
            S_RJ_RD:   if (r_rj_ph) w_state_nxt = (rj_data == 8'd0) ? S_SHIFT : S_COEF_RD;
            S_COEF_RD: w_state_nxt = S_DATA_RD;
            S_DATA_RD: w_state_nxt = S_ADD;
            S_ADD:     if (alu_ready) w_state_nxt = (r_cnt == 8'd1) ? S_SHIFT : S_COEF_RD;
            S_SHIFT:   w_state_nxt = w_last_u ? S_DONE : S_RJ_RD;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        done     = 1'b0;
        alu_sign = 1'b0;
        alu_opA  = '0;
        alu_opB  = '0;
        case (r_state)
            S_RJ_RD, S_COEF_RD, S_SHIFT: busy = 1'b1;
            S_DATA_RD, S_ADD: begin
                busy     = 1'b1;
                alu_sign = r_sign;
                alu_opA  = x_to_operand(data_data);
                alu_opB  = r_acc;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge sClk or negedge ALUReset_n) begin
        if (!ALUReset_n) begin
            r_rj_ph <= 1'b0;
            r_u     <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_y_out <= '0;
            r_sign  <= 1'b0;
        end else begin
            r_rj_ph <= (r_state == S_RJ_RD) && !r_rj_ph;
            case (r_state)
                S_IDLE: if (start) begin
                    r_acc <= '0;
                    r_u   <= '0;
                end
                S_RJ_RD:   if (r_rj_ph) r_cnt <= rj_data;
                S_COEF_RD: r_sign <= coef_data[8];
                S_ADD: if (alu_ready) begin
                    r_acc <= alu_result;
                    r_cnt <= r_cnt - 8'd1;
                end
                S_SHIFT: begin
                    r_acc <= w_acc_shr;
                    r_u   <= r_u + 4'd1;
                    if (w_last_u) r_y_out <= w_acc_shr;
                end
                default: ;
            endcase
        end
    end

`ifdef CONV_OVF_DETECT_EN
    logic r_ovf;
    logic w_a_eff_sign;
    assign w_a_eff_sign = alu_sign ? ~alu_opA[ACC_W-1] : alu_opA[ACC_W-1];

    always_ff @(posedge sClk or negedge ALUReset_n) begin
        if (!ALUReset_n)     r_ovf <= 1'b0;
        else if (w_start_ok) r_ovf <= 1'b0;
        else if (w_add_cap && (alu_opB[ACC_W-1] == w_a_eff_sign)
                 && (alu_result[ACC_W-1] != alu_opB[ACC_W-1]))
            r_ovf <= 1'b1;
    end
    assign ovf = r_ovf;
`endif

    assign rj_addr = r_u;
    assign y_out   = r_y_out;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - self-checking bench for conv_sequencer
module tb_conv_sequencer;

    localparam int NU  = 16;
    localparam int CAW = 9;

    logic           sClk       = 1'b0;
    logic           ALUReset_n = 1'b0;
    logic           start      = 1'b0;
    logic [7:0]     xnew_ptr   = '0;
    logic [3:0]     rj_addr;
    logic [7:0]     rj_data;
    logic [CAW-1:0] coef_addr;
    logic [8:0]     coef_data;
    logic [7:0]     data_addr;
    logic [15:0]    data_data;
    logic           alu_sign;
    logic [39:0]    alu_opA, alu_opB;
    logic [39:0]    alu_result = '0;
    logic           alu_ready  = 1'b0;
    logic           busy, done;
    logic [39:0]    y_out;
`ifdef CONV_OVF_DETECT_EN
    logic           ovf;
`endif

    logic [7:0]  rj_mem   [16];
    logic [8:0]  coef_mem [512];
    logic [15:0] x_mem    [256];
    bit          rdy_rand = 1'b0;

    int total = 0;
    int bad   = 0;

    conv_sequencer #(.NUM_U(NU), .COEF_AW(CAW)) dut (
`ifdef CONV_OVF_DETECT_EN
        .ovf        (ovf),
`endif
        .sClk       (sClk),
        .ALUReset_n (ALUReset_n),
        .start      (start),
        .xnew_ptr   (xnew_ptr),
        .rj_addr    (rj_addr),
        .rj_data    (rj_data),
        .coef_addr  (coef_addr),
        .coef_data  (coef_data),
        .data_addr  (data_addr),
        .data_data  (data_data),
        .alu_sign   (alu_sign),
        .alu_opA    (alu_opA),
        .alu_opB    (alu_opB),
        .alu_result (alu_result),
        .alu_ready  (alu_ready),
        .busy       (busy),
        .done       (done),
        .y_out      (y_out)
    );

    always #5 sClk = ~sClk;

    assign rj_data   = rj_mem[rj_addr];
    assign coef_data = coef_mem[coef_addr];
    assign data_data = x_mem[data_addr];

    // Shared adder: evaluates on the falling edge, optionally stalls.
    always @(negedge sClk) begin
        alu_result <= alu_sign ? alu_opB - alu_opA : alu_opB + alu_opA;
        alu_ready  <= rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    typedef struct {
        int          grp;
        int          n;
        logic [8:0]  coef;
        logic [15:0] x;
        logic [7:0]  ptr;
        logic [39:0] exp_y;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
        end
    endtask

    function automatic logic [39:0] model_y(input logic [7:0] ptr);
        longint     acc;
        longint     term;
        int         idx;
        logic [7:0] a;
        logic [8:0] c;
        acc = 0;
        idx = 0;
        for (int u = 0; u < NU; u++) begin
            for (int j = 0; j < int'(rj_mem[u]); j++) begin
                c = coef_mem[idx % 512];
                idx++;
                a = ptr - c[7:0];
                term = longint'($signed(x_mem[a])) * 65536;
                acc = c[8] ? acc - term : acc + term;
                acc = (acc <<< 24) >>> 24;
            end
            acc = acc >>> 1;
        end
        return acc[39:0];
    endfunction

    function automatic int exp_cycles();
        int s;
        s = 0;
        for (int u = 0; u < NU; u++) s += int'(rj_mem[u]);
        return 3 * NU + 3 * s + 1;
    endfunction

    task automatic clear_mems();
        for (int i = 0; i < 16; i++)  rj_mem[i] = '0;
        for (int i = 0; i < 512; i++) coef_mem[i] = '0;
        for (int i = 0; i < 256; i++) x_mem[i] = '0;
    endtask

    task automatic run_one(input logic [7:0] ptr, input int budget,
                           output int cyc, output int nops, output logic [39:0] y, output bit got);
        @(negedge sClk);
        xnew_ptr = ptr;
        start    = 1'b1;
        cyc  = 0;
        nops = 0;
        do begin
            @(negedge sClk);
            start = 1'b0;
            cyc++;
            if (alu_opA != '0) nops++;
        end while (!done && cyc < budget);
        got = done;
        y   = y_out;
        @(negedge sClk);
    endtask

    initial begin
        vec_t        vecs[7];
        int          cyc, nops, c, ndone;
        logic [39:0] y, exp;
        bit          got;
        logic [7:0]  a;

        clear_mems();
        repeat (2) @(negedge sClk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_y", y_out, 0);
        check("rst_addr", {rj_addr, coef_addr, data_addr}, 0);
        check("rst_alu", {alu_sign, alu_opA, alu_opB}, 0);
`ifdef CONV_OVF_DETECT_EN
        check("rst_ovf", ovf, 0);
`endif
        ALUReset_n = 1'b1;

        vecs[0] = '{0,  0, 9'h000, 16'h1234, 8'h00, 40'h00_0000_0000};
        vecs[1] = '{0,  1, 9'h000, 16'h4000, 8'h20, 40'h00_0000_4000};
        vecs[2] = '{0,  1, 9'h105, 16'h0001, 8'h02, 40'hFF_FFFF_FFFF};
        vecs[3] = '{15, 1, 9'h000, 16'h4000, 8'h07, 40'h00_2000_0000};
        vecs[4] = '{3,  2, 9'h001, 16'h0010, 8'h0A, 40'h00_0000_0100};
        vecs[5] = '{14, 1, 9'h000, 16'h8000, 8'hFF, 40'hFF_E000_0000};
        vecs[6] = '{1,  3, 9'h1FF, 16'h0100, 8'h00, 40'hFF_FFFF_FA00};

        for (int i = 0; i < 7; i++) begin
            clear_mems();
            rj_mem[vecs[i].grp] = 8'(vecs[i].n);
            for (int k = 0; k < 512; k++) coef_mem[k] = vecs[i].coef;
            a = vecs[i].ptr - vecs[i].coef[7:0];
            x_mem[a] = vecs[i].x;
            run_one(vecs[i].ptr, 1000, cyc, nops, y, got);
            check($sformatf("vec%0d_done", i), got, 1);
            check($sformatf("vec%0d_lat", i), cyc, 3 * NU + 3 * vecs[i].n + 1);
            check($sformatf("vec%0d_ops", i), nops, 2 * vecs[i].n);
            check($sformatf("vec%0d_y", i), y, vecs[i].exp_y);
        end

        // Sample address wrap and operand stability through ADD.
        clear_mems();
        rj_mem[0] = 8'd1;
        coef_mem[0] = 9'h105;
        x_mem[8'hFD] = 16'h0001;
        @(negedge sClk);
        xnew_ptr = 8'd2;
        start = 1'b1;
        c = 0;
        do begin
            @(negedge sClk);
            start = 1'b0;
            c++;
        end while (alu_opA == '0 && c < 20);
        check("wrap_seen", c < 20, 1);
        check("wrap_addr", data_addr, 8'hFD);
        check("wrap_sign", alu_sign, 1);
        check("wrap_opA", alu_opA, 40'h00_0001_0000);
        check("wrap_opB", alu_opB, 0);
        @(negedge sClk);
        check("hold_opA", alu_opA, 40'h00_0001_0000);
        check("hold_addr", data_addr, 8'hFD);
        do begin
            @(negedge sClk);
            c++;
        end while (!done && c < 200);
        check("wrap_y", y_out, 40'hFF_FFFF_FFFF);
        @(negedge sClk);

        // Reset in the ADD of group 7, then a fresh run.
        clear_mems();
        for (int u = 0; u < NU; u++) rj_mem[u] = 8'd1;
        for (int i = 0; i < 256; i++) x_mem[i] = 16'h0100;
        exp = model_y(8'h33);
        run_one(8'h33, 1000, cyc, nops, y, got);
        check("pre_rst_y", y, exp);
        @(negedge sClk);
        xnew_ptr = 8'h33;
        start = 1'b1;
        c = 0;
        do begin
            @(negedge sClk);
            start = 1'b0;
            c++;
        end while (!(rj_addr == 4'd7 && alu_opA != '0) && c < 500);
        check("g7_found", c < 500, 1);
        @(negedge sClk);
        ALUReset_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_y", y_out, 0);
        check("mid_rst_alu", alu_opA, 0);
        check("mid_rst_coef", coef_addr, 0);
        @(negedge sClk);
        ALUReset_n = 1'b1;
        run_one(8'h33, 1000, cyc, nops, y, got);
        check("post_rst_y", y, exp);
        check("post_rst_lat", cyc, 3 * NU + 3 * NU + 1);

        // Start while busy must not restart or re-capture the pointer.
        for (int i = 0; i < 256; i++) x_mem[i] = 16'($urandom);
        exp = model_y(8'h10);
        @(negedge sClk);
        xnew_ptr = 8'h10;
        start = 1'b1;
        ndone = 0;
        y = '0;
        for (int k = 0; k < exp_cycles() + 30; k++) begin
            @(negedge sClk);
            start = (k == 10);
            if (k == 10) xnew_ptr = 8'h90;
            if (done) begin
                ndone++;
                y = y_out;
            end
        end
        start = 1'b0;
        check("busy_start_ndone", ndone, 1);
        check("busy_start_y", y, exp);

        // Randomized runs against the reference model.
        for (int it = 0; it < 12; it++) begin
            rdy_rand = it[0];
            for (int u = 0; u < NU; u++) rj_mem[u] = 8'($urandom_range(0, 3));
            for (int i = 0; i < 512; i++) coef_mem[i] = 9'($urandom);
            for (int i = 0; i < 256; i++) x_mem[i] = 16'($urandom);
            a = 8'($urandom);
            exp = model_y(a);
            run_one(a, 3000, cyc, nops, y, got);
            check($sformatf("rnd%0d_done", it), got, 1);
            check($sformatf("rnd%0d_y", it), y, exp);
            if (!rdy_rand) check($sformatf("rnd%0d_lat", it), cyc, exp_cycles());
        end
        rdy_rand = 1'b0;

`ifdef CONV_OVF_DETECT_EN
        clear_mems();
        rj_mem[0] = 8'd255;
        rj_mem[1] = 8'd255;
        for (int i = 0; i < 256; i++) x_mem[i] = 16'h7FFF;
        exp = model_y(8'h00);
        run_one(8'h00, 4000, cyc, nops, y, got);
        check("ovf_set", ovf, 1);
        check("ovf_y", y, exp);
        rj_mem[0] = 8'd0;
        rj_mem[1] = 8'd0;
        run_one(8'h00, 200, cyc, nops, y, got);
        check("ovf_clear", ovf, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
